mul_t_c3x3_sched: RTL and testbench

//  Shares one precision-configurable 27x27 multiplier among NREQ requesters using round-robin arbitration.
//  The multiplier supports three modes: 27x27, sum-of-9x9 and sum-of-4x4.
//  The multiplier samples mode and a_sign/b_sign unregistered on its output side, so this block keeps them stable while any op is in flight.
//  It drains the pipeline on every configuration change and returns tagged results through a credit-protected result FIFO.

---
 rtl/mul_t_c3x3_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_mul_t_c3x3_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_t_c3x3_sched.sv
// Round-robin scheduler sharing one 27x27 / sum-of-9x9 / sum-of-4x4 multiplier among NREQ requesters.
// Optional perf counters: define MLB_MUL_SCHED_PERF_EN.
module mul_t_c3x3_sched #(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = 2,
  parameter int RES_DEPTH = 4,
  parameter int ID_W      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_mode,
  input  logic [NREQ-1:0]      req_a_sign,
  input  logic [NREQ-1:0]      req_b_sign,
  input  logic [81*NREQ-1:0]   req_a,
  input  logic [81*NREQ-1:0]   req_b,
  output logic [80:0]          mul_a,
  output logic [80:0]          mul_b,
  output logic                 mul_a_sign,
  output logic                 mul_b_sign,
  output logic [1:0]           mul_mode,
  input  logic [53:0]          mul_result_0,
  input  logic [53:0]          mul_result_1,
  input  logic [11:0]          mul_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           rsp_mode,
  output logic [53:0]          rsp_result_0,
  output logic [53:0]          rsp_result_1,
  output logic [11:0]          rsp_carry,
  output logic                 err_mode
`ifdef MLB_MUL_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_drain
`endif
);

  localparam int CNT_W = $clog2(RES_DEPTH + MUL_LAT + 1);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      mode;
    logic [53:0]     r0;
    logic [53:0]     r1;
    logic [11:0]     carry;
  } rsp_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic              tag_valid_reg [MUL_LAT];
  logic [ID_W-1:0]   tag_id_reg    [MUL_LAT];
  logic [1:0]        tag_mode_reg  [MUL_LAT];
  rsp_t              fifo_mem      [RES_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_count_reg;

  logic [80:0]       a_arr [NREQ];
  logic [80:0]       b_arr [NREQ];
  logic [1:0]        eff_mode [NREQ];
  logic [NREQ-1:0]   key_match;
  logic [NREQ-1:0]   is_illegal;
  logic [NREQ-1:0]   cand;

  logic [ID_W-1:0]   grant_idx, win_idx;
  logic              grant_any, win_any;
  logic [CNT_W-1:0]  inflight;
  logic              credit_ok;
  logic              push, pop;
  rsp_t              head, push_entry;

  // Illegal mode 11 is treated as sum-of-9x9 for both matching and issue.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_arr[gi]      = req_a[81*gi +: 81];
      assign b_arr[gi]      = req_b[81*gi +: 81];
      assign is_illegal[gi] = &req_mode[2*gi +: 2];
      assign eff_mode[gi]   = is_illegal[gi] ? 2'b01 : req_mode[2*gi +: 2];
      assign key_match[gi]  = req_valid[gi] && (eff_mode[gi] == mul_mode) &&
                              (req_a_sign[gi] == mul_a_sign) && (req_b_sign[gi] == mul_b_sign);
    end
  endgenerate

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++)
      inflight = inflight + CNT_W'(tag_valid_reg[i]);
  end

  assign credit_ok = (fifo_count_reg + inflight) < CNT_W'(RES_DEPTH);
  assign cand      = (state_reg == RUN && credit_ok && !reset) ? key_match : '0;

  // Two round-robin searches from the same pointer: matching grants, and the
  // next-key winner over all valid requesters used when leaving DRAIN.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    win_any   = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_reg) + off;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!grant_any && cand[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
      if (!win_any && req_valid[idx]) begin
        win_any = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  assign push       = tag_valid_reg[MUL_LAT-1];
  assign pop        = rsp_valid && rsp_ready;
  assign push_entry = '{id: tag_id_reg[MUL_LAT-1], mode: tag_mode_reg[MUL_LAT-1],
                        r0: mul_result_0, r1: mul_result_1, carry: mul_carry};

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= push_entry;
  end

  assign head         = fifo_mem[rd_ptr_reg];
  assign rsp_valid    = (fifo_count_reg != '0);
  assign rsp_id       = rsp_valid ? head.id    : '0;
  assign rsp_mode     = rsp_valid ? head.mode  : '0;
  assign rsp_result_0 = rsp_valid ? head.r0    : '0;
  assign rsp_result_1 = rsp_valid ? head.r1    : '0;
  assign rsp_carry    = rsp_valid ? head.carry : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      rr_ptr_reg     <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_a_sign     <= 1'b0;
      mul_b_sign     <= 1'b0;
      mul_mode       <= 2'b00;
      err_mode       <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_id_reg[i]    <= '0;
        tag_mode_reg[i]  <= '0;
      end
`ifdef MLB_MUL_SCHED_PERF_EN
      perf_issued    <= '0;
      perf_drain     <= '0;
`endif
    end else begin
      case (state_reg)
        RUN: begin
          if (|req_valid && !(|key_match))
            state_reg <= DRAIN;
        end
        DRAIN: begin
          // The key only moves once every op of the old epoch has been captured.
          if (inflight == '0) begin
            if (win_any) begin
              mul_mode   <= eff_mode[win_idx];
              mul_a_sign <= req_a_sign[win_idx];
              mul_b_sign <= req_b_sign[win_idx];
              state_reg  <= SWITCH;
            end else begin
              state_reg  <= RUN;
            end
          end
        end
        default: state_reg <= RUN;
      endcase

      if (grant_any) begin
        mul_a      <= a_arr[grant_idx];
        mul_b      <= b_arr[grant_idx];
        rr_ptr_reg <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        if (is_illegal[grant_idx])
          err_mode <= 1'b1;
      end

      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= grant_idx;
      tag_mode_reg[0]  <= mul_mode;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_id_reg[i]    <= tag_id_reg[i-1];
        tag_mode_reg[i]  <= tag_mode_reg[i-1];
      end

      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RES_DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RES_DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
      if (push && !pop)
        fifo_count_reg <= fifo_count_reg + 1'b1;
      else if (!push && pop)
        fifo_count_reg <= fifo_count_reg - 1'b1;

`ifdef MLB_MUL_SCHED_PERF_EN
      if (grant_any && perf_issued != 32'hFFFFFFFF)
        perf_issued <= perf_issued + 32'd1;
      if ((state_reg == DRAIN || state_reg == SWITCH) && perf_drain != 32'hFFFFFFFF)
        perf_drain <= perf_drain + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mul_t_c3x3_sched.sv
// Scoreboard bench for mul_t_c3x3_sched with a behavioural multiplier whose
// output stage samples mode/signs live, so early key changes corrupt results.
module tb_mul_t_c3x3_sched;
  localparam int NREQ = 4, MUL_LAT = 2, RES_DEPTH = 4, ID_W = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [2*NREQ-1:0] req_mode = '0;
  logic [NREQ-1:0] req_a_sign = '0, req_b_sign = '0;
  logic [81*NREQ-1:0] req_a = '0, req_b = '0;
  logic [80:0] mul_a, mul_b;
  logic mul_a_sign, mul_b_sign;
  logic [1:0] mul_mode;
  logic [53:0] mul_result_0, mul_result_1;
  logic [11:0] mul_carry;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [ID_W-1:0] rsp_id;
  logic [1:0] rsp_mode;
  logic [53:0] rsp_result_0, rsp_result_1;
  logic [11:0] rsp_carry;
  logic err_mode;
`ifdef MLB_MUL_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_drain;
`endif

  mul_t_c3x3_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a_sign(req_a_sign), .req_b_sign(req_b_sign), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign),
    .mul_mode(mul_mode), .mul_result_0(mul_result_0), .mul_result_1(mul_result_1),
    .mul_carry(mul_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_mode(rsp_mode), .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
    .rsp_carry(rsp_carry), .err_mode(err_mode)
`ifdef MLB_MUL_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_drain(perf_drain)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      mode;
    logic [119:0]    res;
  } exp_t;
  exp_t sb_q[$];
  int grant_log[$];
  logic [NREQ-1:0] last_grant = '0;
  logic illegal_seen = 1'b0;

  function automatic longint lane(input logic [80:0] v, input int lo, input int w, input logic sg);
    logic [80:0] t;
    longint x;
    t = (v >> lo) & ((81'(1) << w) - 81'(1));
    x = longint'(t[63:0]);
    if (sg && x[w-1])
      x = x - (longint'(1) << w);
    return x;
  endfunction

  // Arithmetic meaning of each mode: result_0/result_1 are lane-product sums, carry tags the mode.
  function automatic logic [119:0] mulf(input logic [80:0] a, input logic [80:0] b,
                                        input logic [1:0] m, input logic as, input logic bs);
    longint s0, s1;
    logic [11:0] c;
    s0 = 0; s1 = 0; c = '0;
    case (m)
      2'b00: s0 = lane(a, 0, 27, as) * lane(b, 0, 27, bs);
      2'b01: begin
        for (int i = 0; i < 9; i++)
          if (i < 5) s0 += lane(a, 9*i, 9, as) * lane(b, 9*i, 9, bs);
          else       s1 += lane(a, 9*i, 9, as) * lane(b, 9*i, 9, bs);
        c = 12'h001;
      end
      2'b10: begin
        for (int i = 0; i < 20; i++)
          if (i < 10) s0 += lane(a, 4*i, 4, as) * lane(b, 4*i, 4, bs);
          else        s1 += lane(a, 4*i, 4, as) * lane(b, 4*i, 4, bs);
        c = {8'h20, a[80], b[80], 2'b10};
      end
      default: c = 12'hFFF;
    endcase
    return {s0[53:0], s1[53:0], c};
  endfunction

  logic [80:0] bfm_a_reg = '0, bfm_b_reg = '0;
  always @(posedge clk) begin
    bfm_a_reg <= mul_a;
    bfm_b_reg <= mul_b;
  end
  assign {mul_result_0, mul_result_1, mul_carry} = mulf(bfm_a_reg, bfm_b_reg, mul_mode, mul_a_sign, mul_b_sign);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: grants push expectations, response handshakes pop and compare.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      last_grant = '0;
      illegal_seen = 1'b0;
    end else begin
      last_grant = req_ready;
      if (req_ready != '0) begin
        int g;
        logic [1:0] m, em;
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("grant_legal", 128'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 128'(1));
        m  = req_mode[2*g +: 2];
        em = (m == 2'b11) ? 2'b01 : m;
        if (m == 2'b11) illegal_seen = 1'b1;
        sb_q.push_back('{id: ID_W'(g), mode: em,
                         res: mulf(req_a[81*g +: 81], req_b[81*g +: 81], em, req_a_sign[g], req_b_sign[g])});
        grant_log.push_back(g);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("stale_rsp", 128'(rsp_id), 128'hDEAD);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("rsp id=%0d mode=%0d r0=%0h r1=%0h c=%0h", rsp_id, rsp_mode, rsp_result_0, rsp_result_1, rsp_carry);
          chk("rsp_payload", {rsp_id, rsp_mode, rsp_result_0, rsp_result_1, rsp_carry}, 128'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [80:0] rnd81();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[80:0];
  endfunction

  task automatic set_req(input int i, input logic [1:0] m, input logic as, input logic bs,
                         input logic [80:0] a, input logic [80:0] b);
    req_mode[2*i +: 2] = m;
    req_a_sign[i] = as;
    req_b_sign[i] = bs;
    req_a[81*i +: 81] = a;
    req_b[81*i +: 81] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic reload_granted(input logic [1:0] m, input logic as, input logic bs);
    for (int i = 0; i < NREQ; i++)
      if (last_grant[i]) set_req(i, m, as, bs, rnd81(), rnd81());
  endtask

  task automatic drop_granted();
    for (int i = 0; i < NREQ; i++)
      if (last_grant[i]) req_valid[i] = 1'b0;
  endtask

  task automatic wait_grant(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 40);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((sb_q.size() != 0 || rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("idle_drained", 128'(sb_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n, g0;
    logic saw_rsp;
`ifdef MLB_MUL_SCHED_PERF_EN
    logic [31:0] pd0;
`endif
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_mul_mode", 128'({mul_mode, mul_a_sign, mul_b_sign}), 128'(0));
    chk("reset_err", 128'(err_mode), 128'(0));
    tick();

    // Directed 3x5 with latency from grant to response head.
    set_req(0, 2'b00, 1'b0, 1'b0, 81'h3, 81'h5);
    @(negedge clk);
    chk("t1_grant", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk("t1_latency", 128'(n), 128'(3));
    chk("t1_id", 128'(rsp_id), 128'(0));
    chk("t1_result", 128'(rsp_result_0), 128'(54'd15));
    wait_idle();

    // All four valid with the same key: strict rotation from pointer 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 1'b0, 1'b0, rnd81(), rnd81());
    grant_log.delete();
    repeat (8) begin
      tick();
      reload_granted(2'b00, 1'b0, 1'b0);
    end
    req_valid = '0;
    chk("t2_grant_count", 128'(grant_log.size()), 128'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("t2_rr_order", 128'(grant_log[i]), 128'(i % NREQ));
    wait_idle();

    // Mode change 00 -> 01: drain two in-flight ops, one switch cycle, then grant.
    set_req(0, 2'b00, 1'b0, 1'b0, rnd81(), rnd81());
    repeat (5) begin
      tick();
      reload_granted(2'b00, 1'b0, 1'b0);
    end
    tick();
    drop_granted();
    req_valid[0] = 1'b0;
    set_req(1, 2'b01, 1'b0, 1'b0, rnd81(), rnd81());
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 3 && !req_ready[1]) chk("t3_mode_held", 128'(mul_mode), 128'(0));
    end while (!req_ready[1] && n < 40);
    chk("t3_switch_latency", 128'(n), 128'(5));
    chk("t3_new_mode", 128'(mul_mode), 128'(2'b01));
    tick();
    req_valid = '0;
    wait_idle();

    // Same mode, sign changes force drains.
`ifdef MLB_MUL_SCHED_PERF_EN
    pd0 = perf_drain;
`endif
    tick();
    set_req(0, 2'b01, 1'b1, 1'b1, rnd81(), rnd81());
    wait_grant(0, n);
    chk("t4_signed_latency", 128'(n), 128'(4));
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 2'b01, 1'b0, 1'b0, rnd81(), rnd81());
    wait_grant(1, n);
    chk("t4_unsigned_latency", 128'(n), 128'(5));
`ifdef MLB_MUL_SCHED_PERF_EN
    chk("t4_perf_drain", 128'(perf_drain - pd0), 128'(5));
`endif
    tick();
    req_valid = '0;
    wait_idle();

    // Back-pressure: credits cap issued ops at the FIFO depth.
    rsp_ready = 1'b0;
    g0 = grant_log.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 1'b0, 1'b0, rnd81(), rnd81());
    repeat (20) begin
      tick();
      reload_granted(2'b01, 1'b0, 1'b0);
    end
    chk("t5_grants_capped", 128'(grant_log.size() - g0), 128'(RES_DEPTH));
    chk("t5_fifo_head", 128'(rsp_valid), 128'(1));
    rsp_ready = 1'b1;
    repeat (20) begin
      tick();
      reload_granted(2'b01, 1'b0, 1'b0);
    end
    req_valid = '0;
    wait_idle();

    // Reset with two ops in flight, one of them an illegal mode.
    set_req(0, 2'b01, 1'b0, 1'b0, rnd81(), rnd81());
    set_req(1, 2'b11, 1'b0, 1'b0, rnd81(), rnd81());
    g0 = grant_log.size();
    n = 0;
    while (grant_log.size() - g0 < 2 && n < 20) begin
      tick();
      drop_granted();
      n++;
    end
    chk("t6_err_set", 128'(err_mode), 128'(1));
    reset = 1'b1;
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("t6_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t6_req_ready", 128'(req_ready), 128'(0));
    chk("t6_mul_mode", 128'(mul_mode), 128'(0));
    chk("t6_err_clr", 128'(err_mode), 128'(0));
    tick();
    reset = 1'b0;
    saw_rsp = 1'b0;
    repeat (10) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("t6_no_stale", 128'(saw_rsp), 128'(0));

    // Random mixed keys, including illegal mode, with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      tick();
      drop_granted();
      rsp_ready = ($urandom % 3) != 0;
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && ($urandom % 4) == 0)
          set_req(i, 2'($urandom % 4), ($urandom % 4) == 0, ($urandom % 4) == 0, rnd81(), rnd81());
    end
    n = 0;
    while (req_valid != '0 && n < 500) begin
      tick();
      drop_granted();
      rsp_ready = ($urandom % 3) != 0;
      n++;
    end
    chk("rand_all_served", 128'(req_valid), 128'(0));
    wait_idle();
    chk("rand_err_sticky", 128'(err_mode), 128'(illegal_seen));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
